hazard_forward_unit: RTL and testbench

//  Parametrised successor to the single-result EX bypass selector. Per EX source port: forwarding
//  mux select from EX/MEM or MEM/WB. Also owns ID-stage interlocks: load-use stall FSM and a
//  one-entry scoreboard for the multi-cycle multiply/divide unit (MDU).

---
 rtl/hazard_forward_unit_if.sv | 36 +++
 rtl/hazard_forward_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
// Decode-side bundle for the hazard/forwarding unit: register numbers and write
// qualifiers from ID/EX/MEM/WB, plus the returned mux selects and stall controls.
interface hazard_forward_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5
);
  logic [NUM_SRC*REG_AW-1:0] src_num_ex;
  logic [NUM_SRC*REG_AW-1:0] src_num_id;
  logic [NUM_SRC-1:0]        src_used_id;
  logic [REG_AW-1:0]         dst_ex;
  logic                      wen_ex;
  logic                      load_ex;
  logic [REG_AW-1:0]         dst_mem;
  logic                      wen_mem;
  logic                      load_mem;
  logic [REG_AW-1:0]         dst_wb;
  logic                      wen_wb;
  logic                      mdu_issue_id;
  logic [REG_AW-1:0]         mdu_dst_id;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall;
  logic                      bubble;
  logic                      mdu_busy;

  modport master (
    output src_num_ex, src_num_id, src_used_id, dst_ex, wen_ex, load_ex,
           dst_mem, wen_mem, load_mem, dst_wb, wen_wb, mdu_issue_id, mdu_dst_id,
    input  fwd_sel, stall, bubble, mdu_busy
  );

  modport slave (
    input  src_num_ex, src_num_id, src_used_id, dst_ex, wen_ex, load_ex,
           dst_mem, wen_mem, load_mem, dst_wb, wen_wb, mdu_issue_id, mdu_dst_id,
    output fwd_sel, stall, bubble, mdu_busy
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// EX bypass select per source port, plus ID interlocks: load-use hold FSM and a
// one-entry scoreboard tracking the in-flight multi-cycle MDU result.
module hfu_src_lane #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_ex_i,
  input  logic [REG_AW-1:0] src_id_i,
  input  logic              used_id_i,
  input  logic [REG_AW-1:0] dst_ex_i,
  input  logic [REG_AW-1:0] dst_mem_i,
  input  logic              wen_mem_i,
  input  logic              load_mem_i,
  input  logic [REG_AW-1:0] dst_wb_i,
  input  logic              wen_wb_i,
  input  logic [REG_AW-1:0] sb_reg_i,
  output logic [1:0]        sel_o,
  output logic              lu_match_o,
  output logic              sb_match_o
);
  // A load in MEM has no data yet, so only WB may supply it.
  always_comb begin
    sel_o = 2'b00;
    if (wen_mem_i && dst_mem_i != '0 && dst_mem_i == src_ex_i && !load_mem_i)
      sel_o = 2'b01;
    else if (wen_wb_i && dst_wb_i != '0 && dst_wb_i == src_ex_i)
      sel_o = 2'b10;
  end

  assign lu_match_o = used_id_i && (src_id_i == dst_ex_i);
  assign sb_match_o = used_id_i && (src_id_i == sb_reg_i);
endmodule

module hazard_forward_unit #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_forward_unit_if.slave  bus
);
  localparam int LCW = $clog2(LOAD_LAT + 1);
  localparam int MCW = $clog2(MDU_LAT + 1);

  typedef enum logic [0:0] {IDLE, LOAD_HOLD} state_e;

  state_e              state_q, state_d;
  logic [LCW-1:0]      lcnt_q, lcnt_d;
  logic                sb_vld_q, sb_vld_d;
  logic [REG_AW-1:0]   sb_reg_q, sb_reg_d;
  logic [MCW-1:0]      mcnt_q, mcnt_d;

  logic [NUM_SRC-1:0][1:0] sel;
  logic [NUM_SRC-1:0]      lu_match, sb_match;
  logic                    lu_hit, sb_hit, ld_stall, stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    hfu_src_lane #(.REG_AW(REG_AW)) u_lane (
      .src_ex_i   (bus.src_num_ex[i*REG_AW +: REG_AW]),
      .src_id_i   (bus.src_num_id[i*REG_AW +: REG_AW]),
      .used_id_i  (bus.src_used_id[i]),
      .dst_ex_i   (bus.dst_ex),
      .dst_mem_i  (bus.dst_mem),
      .wen_mem_i  (bus.wen_mem),
      .load_mem_i (bus.load_mem),
      .dst_wb_i   (bus.dst_wb),
      .wen_wb_i   (bus.wen_wb),
      .sb_reg_i   (sb_reg_q),
      .sel_o      (sel[i]),
      .lu_match_o (lu_match[i]),
      .sb_match_o (sb_match[i])
    );
  end

  assign lu_hit = bus.load_ex && bus.wen_ex && (bus.dst_ex != '0) && (|lu_match);
  // A second MDU op must also wait: the scoreboard holds only one entry.
  assign sb_hit = sb_vld_q && ((|sb_match) || (bus.wen_ex && bus.dst_ex == sb_reg_q) ||
                               bus.mdu_issue_id);

  always_comb begin
    state_d  = state_q;
    lcnt_d   = lcnt_q;
    ld_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (lu_hit) begin
          ld_stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LOAD_HOLD;
            lcnt_d  = LCW'(LOAD_LAT - 1);
          end
        end
      end
      LOAD_HOLD: begin
        ld_stall = 1'b1;
        lcnt_d   = lcnt_q - LCW'(1);
        if (lcnt_q == LCW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = ld_stall || sb_hit;

  // The MDU counts down even while the pipe is stalled; it runs on its own.
  always_comb begin
    sb_vld_d = sb_vld_q;
    sb_reg_d = sb_reg_q;
    mcnt_d   = mcnt_q;
    if (sb_vld_q) begin
      mcnt_d = mcnt_q - MCW'(1);
      if (mcnt_q == MCW'(1)) sb_vld_d = 1'b0;
    end else if (bus.mdu_issue_id && !stall && bus.mdu_dst_id != '0) begin
      sb_vld_d = 1'b1;
      sb_reg_d = bus.mdu_dst_id;
      mcnt_d   = MCW'(MDU_LAT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lcnt_q   <= '0;
      sb_vld_q <= 1'b0;
      sb_reg_q <= '0;
      mcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      lcnt_q   <= lcnt_d;
      sb_vld_q <= sb_vld_d;
      sb_reg_q <= sb_reg_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign bus.fwd_sel  = sel;
  assign bus.stall    = stall;
  assign bus.bubble   = stall;
  assign bus.mdu_busy = sb_vld_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Two instances (LOAD_LAT=1 and 3) share one input stream; a cycle-level model
// of stall windows and MDU result lifetime checks them every cycle.
module tb_hazard_forward_unit;
  localparam int NS = 2;
  localparam int AW = 5;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS*AW-1:0] src_ex, src_id;
  logic [NS-1:0]    used;
  logic [AW-1:0]    dex, dmem, dwb, mdst;
  logic             wex, lex, wmem, lmem, wwb, miss;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hazard_forward_unit_if #(.NUM_SRC(NS), .REG_AW(AW)) if1 ();
  hazard_forward_unit_if #(.NUM_SRC(NS), .REG_AW(AW)) if3 ();

  assign if1.src_num_ex = src_ex;  assign if3.src_num_ex = src_ex;
  assign if1.src_num_id = src_id;  assign if3.src_num_id = src_id;
  assign if1.src_used_id = used;   assign if3.src_used_id = used;
  assign if1.dst_ex = dex;         assign if3.dst_ex = dex;
  assign if1.wen_ex = wex;         assign if3.wen_ex = wex;
  assign if1.load_ex = lex;        assign if3.load_ex = lex;
  assign if1.dst_mem = dmem;       assign if3.dst_mem = dmem;
  assign if1.wen_mem = wmem;       assign if3.wen_mem = wmem;
  assign if1.load_mem = lmem;      assign if3.load_mem = lmem;
  assign if1.dst_wb = dwb;         assign if3.dst_wb = dwb;
  assign if1.wen_wb = wwb;         assign if3.wen_wb = wwb;
  assign if1.mdu_issue_id = miss;  assign if3.mdu_issue_id = miss;
  assign if1.mdu_dst_id = mdst;    assign if3.mdu_dst_id = mdst;

  hazard_forward_unit #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(1), .MDU_LAT(ML)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1));
  hazard_forward_unit #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(3), .MDU_LAT(ML)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3));

  logic [2*NS-1:0] a_fwd [2];
  logic            a_st  [2];
  logic            a_bub [2];
  logic            a_busy[2];
  assign a_fwd[0] = if1.fwd_sel;  assign a_fwd[1] = if3.fwd_sel;
  assign a_st[0]  = if1.stall;    assign a_st[1]  = if3.stall;
  assign a_bub[0] = if1.bubble;   assign a_bub[1] = if3.bubble;
  assign a_busy[0] = if1.mdu_busy; assign a_busy[1] = if3.mdu_busy;

  // Model: remaining forced load-stall cycles, and the MDU result's destination
  // plus how many more cycles until it is available.
  int          lat[2] = '{1, 3};
  int          ld_rem[2] = '{0, 0};
  bit          sbv[2] = '{0, 0};
  logic [AW-1:0] sbr[2];
  int          sbl[2] = '{0, 0};

  function automatic logic [AW-1:0] sx(input int i);
    return src_ex[i*AW +: AW];
  endfunction
  function automatic logic [AW-1:0] sd(input int i);
    return src_id[i*AW +: AW];
  endfunction

  function automatic logic [2*NS-1:0] m_fwd();
    logic [2*NS-1:0] r = '0;
    for (int i = 0; i < NS; i++) begin
      if (wmem && dmem != 0 && dmem == sx(i) && !lmem) r[2*i +: 2] = 2'b01;
      else if (wwb && dwb != 0 && dwb == sx(i))        r[2*i +: 2] = 2'b10;
    end
    return r;
  endfunction

  function automatic bit m_lu();
    bit hit = 1'b0;
    for (int i = 0; i < NS; i++)
      if (used[i] && sd(i) == dex) hit = 1'b1;
    return lex && wex && dex != 0 && hit;
  endfunction

  function automatic bit m_stall(input int k);
    bit sb = 1'b0;
    if (sbv[k]) begin
      for (int i = 0; i < NS; i++)
        if (used[i] && sd(i) == sbr[k]) sb = 1'b1;
      if (wex && dex == sbr[k]) sb = 1'b1;
      if (miss) sb = 1'b1;
    end
    return (ld_rem[k] == 0 && m_lu()) || ld_rem[k] > 0 || sb;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit st;
      st = m_stall(k);
      if (rst) begin
        ld_rem[k] <= 0;
        sbv[k]    <= 1'b0;
        sbl[k]    <= 0;
      end else begin
        if (ld_rem[k] > 0)  ld_rem[k] <= ld_rem[k] - 1;
        else if (m_lu())    ld_rem[k] <= lat[k] - 1;
        if (sbv[k]) begin
          sbl[k] <= sbl[k] - 1;
          if (sbl[k] == 1) sbv[k] <= 1'b0;
        end else if (miss && !st && mdst != 0) begin
          sbv[k] <= 1'b1;
          sbr[k] <= mdst;
          sbl[k] <= ML;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit es;
        es = m_stall(k);
        chk(k == 0 ? "m1_fwd_sel" : "m3_fwd_sel", 32'(a_fwd[k]), 32'(m_fwd()));
        chk(k == 0 ? "m1_stall"   : "m3_stall",   32'(a_st[k]),  32'(es));
        chk(k == 0 ? "m1_bubble"  : "m3_bubble",  32'(a_bub[k]), 32'(es));
        chk(k == 0 ? "m1_busy"    : "m3_busy",    32'(a_busy[k]), 32'(sbv[k]));
      end
    end
  end

  task automatic idle();
    src_ex = '0; src_id = '0; used = '0;
    dex = '0; dmem = '0; dwb = '0; mdst = '0;
    wex = 0; lex = 0; wmem = 0; lmem = 0; wwb = 0; miss = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input logic s1, input logic s3, input logic b);
    @(negedge clk);
    chk({nm, "_stall1"}, 32'(if1.stall), 32'(s1));
    chk({nm, "_stall3"}, 32'(if3.stall), 32'(s3));
    chk({nm, "_busy"},   32'(if1.mdu_busy), 32'(b));
  endtask

  function automatic logic [AW-1:0] rr();
    return ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    pin("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_fwd", 32'(if1.fwd_sel), 32'h0);

    // double match: MEM wins on both ports
    tick(); idle();
    src_ex = {5'd8, 5'd8}; wmem = 1; dmem = 8; wwb = 1; dwb = 8;
    pin("dbl", 1'b0, 1'b0, 1'b0);
    chk("dbl_fwd", 32'(if1.fwd_sel), 32'h5);

    // load-use: lw r9 in EX, ID reads r9
    tick(); idle();
    lex = 1; wex = 1; dex = 9; src_id = {5'd1, 5'd9}; used = 2'b11;
    pin("lu_c0", 1'b1, 1'b1, 1'b0);
    tick();
    lex = 0; wex = 0; dex = 0; wmem = 1; dmem = 9; lmem = 1; src_ex = {5'd1, 5'd9};
    pin("lu_c1", 1'b0, 1'b1, 1'b0);
    chk("lu_memload_fwd", 32'(if1.fwd_sel), 32'h0);
    tick();
    pin("lu_c2", 1'b0, 1'b1, 1'b0);
    tick();
    pin("lu_c3", 1'b0, 1'b0, 1'b0);
    tick(); idle();
    src_ex = {5'd1, 5'd9}; wwb = 1; dwb = 9;
    pin("lu_wb", 1'b0, 1'b0, 1'b0);
    chk("lu_wb_fwd", 32'(if3.fwd_sel), 32'h2);

    // MDU r12, consumer stalls 4 cycles
    tick(); idle();
    miss = 1; mdst = 12;
    pin("mdu_iss", 1'b0, 1'b0, 1'b0);
    tick(); idle();
    src_id = {5'd0, 5'd12}; used = 2'b01;
    for (int j = 1; j <= 5; j++) begin
      pin("mdu_wait", j < 5, j < 5, j < 5);
      tick();
    end

    // everything targets r0
    idle();
    wmem = 1; wwb = 1; lex = 1; wex = 1; used = 2'b11; miss = 1;
    pin("r0_a", 1'b0, 1'b0, 1'b0);
    chk("r0_fwd", 32'(if3.fwd_sel), 32'h0);
    tick();
    pin("r0_b", 1'b0, 1'b0, 1'b0);

    // reset in mid MDU and mid load hold
    tick(); idle();
    miss = 1; mdst = 12;
    tick(); idle();
    src_id = {5'd0, 5'd12}; used = 2'b01;
    tick();
    lex = 1; wex = 1; dex = 7; src_id = {5'd7, 5'd12}; used = 2'b11;
    tick();
    lex = 0; wex = 0; dex = 0; rst = 1'b1;
    pin("rst_mid", 1'b1, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    pin("rst_after", 1'b0, 1'b0, 1'b0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst    = ($urandom_range(0, 60) == 0);
      src_ex = {rr(), rr()};
      src_id = {rr(), rr()};
      used   = NS'($urandom_range(0, 3));
      dex  = rr(); wex  = $urandom_range(0, 1) == 1; lex  = $urandom_range(0, 2) == 0;
      dmem = rr(); wmem = $urandom_range(0, 1) == 1; lmem = $urandom_range(0, 3) == 0;
      dwb  = rr(); wwb  = $urandom_range(0, 1) == 1;
      miss = $urandom_range(0, 5) == 0; mdst = rr();
    end
    tick();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
